// File: rtl/dsp_boot_seq_pkg.sv
// dsp_boot_pkg: state encoding and default strap constants shared with the board top.
package dsp_boot_pkg;
    typedef enum logic [2:0] {
        S_POR   = 3'd0,
        S_SETUP = 3'd1,
        S_HOLD  = 3'd2,
        S_WAIT  = 3'd3,
        S_RUN   = 3'd4,
        S_FAULT = 3'd5
    } state_e;
    localparam logic [12:0] BOOT_MODE_DEF = 13'b101_1100000_110;
    localparam logic        ENDIAN_DEF    = 1'b1;
endpackage

// File: rtl/dsp_boot_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk_sys or negedge rst_sys_n)
        if (!rst_sys_n) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
endmodule

// File: rtl/dsp_boot_seq.sv
// dsp_boot_seq: C6678 POR/RESETFULL and boot-strap sequencer with retry/fault handling.
// Optional DSP heartbeat supervision is enabled by defining DSP_HEARTBEAT_EN.
module dsp_boot_seq
    import dsp_boot_pkg::*;
#(
    parameter logic [12:0] BOOT_MODE = BOOT_MODE_DEF,
    parameter logic        ENDIAN    = ENDIAN_DEF,
    parameter int          T_POR     = 1000,
    parameter int          T_SETUP   = 200,
    parameter int          T_HOLD    = 200,
    parameter int          T_STAT_TO = 100000,
    parameter int          MAX_RETRY = 3,
    parameter int          CNT_W     = 20
`ifdef DSP_HEARTBEAT_EN
    , parameter int        T_HB      = 50_000_000
`endif
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        boot_req,
    input  logic        dsp_rstn_state,
    output logic        dsp_porn,
    output logic        dsp_resetfulln,
    output logic        strap_oe,
    output logic [12:0] strap_val,
    output logic        endian_val,
    output logic        boot_done,
    output logic        boot_fault,
    output logic [1:0]  retry_cnt
`ifdef DSP_HEARTBEAT_EN
    , input  logic      dsp_hb,
    output logic        hb_lost
`endif
);
    localparam logic [1:0] MAXR = 2'(MAX_RETRY);
    state_e state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic [1:0] retry_d;
    logic rs, fail, hb_fail;
    sync_2ff u_sync_rs (.clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .d(dsp_rstn_state), .q(rs));
    always_comb begin
        state_d = state;
        timer_d = timer - 1'b1;
        retry_d = retry_cnt;
        fail    = 1'b0;
        case (state)
            S_POR:   if (timer == '0) begin state_d = S_SETUP; timer_d = CNT_W'(T_SETUP - 1); end
            S_SETUP: if (timer == '0) begin state_d = S_HOLD; timer_d = CNT_W'(T_HOLD - 1); end
            S_HOLD:  if (timer == '0) begin state_d = S_WAIT; timer_d = CNT_W'(T_STAT_TO - 1); end
            S_WAIT:  if (rs) state_d = S_RUN; else fail = timer == '0;
            S_RUN:   if (boot_req) begin state_d = S_POR; timer_d = CNT_W'(T_POR - 1); retry_d = '0; end
                     else fail = !rs || hb_fail;
            S_FAULT: if (boot_req) begin state_d = S_POR; timer_d = CNT_W'(T_POR - 1); retry_d = '0; end
            default: begin state_d = S_POR; timer_d = CNT_W'(T_POR - 1); end
        endcase
        if (fail) begin
            state_d = (retry_cnt < MAXR) ? S_POR : S_FAULT;
            timer_d = CNT_W'(T_POR - 1);
            retry_d = (retry_cnt < MAXR) ? retry_cnt + 2'd1 : retry_cnt;
        end
    end
    // Pad controls are decoded from the next state so every output is a flop.
    always_ff @(posedge clk_sys or negedge rst_sys_n)
        if (!rst_sys_n) begin
            state          <= S_POR;
            timer          <= CNT_W'(T_POR - 1);
            dsp_porn       <= 1'b0;
            dsp_resetfulln <= 1'b0;
            strap_oe       <= 1'b1;
            strap_val      <= BOOT_MODE;
            endian_val     <= ENDIAN;
            boot_done      <= 1'b0;
            boot_fault     <= 1'b0;
            retry_cnt      <= 2'd0;
        end else begin
            state          <= state_d;
            timer          <= timer_d;
            dsp_porn       <= !(state_d inside {S_POR, S_FAULT});
            dsp_resetfulln <= state_d inside {S_HOLD, S_WAIT, S_RUN};
            strap_oe       <= state_d inside {S_POR, S_SETUP, S_HOLD};
            strap_val      <= BOOT_MODE;
            endian_val     <= ENDIAN;
            boot_done      <= state_d == S_RUN;
            boot_fault     <= state_d == S_FAULT;
            retry_cnt      <= retry_d;
        end
`ifdef DSP_HEARTBEAT_EN
    localparam int HB_W = $clog2(T_HB + 1);
    logic hb_s, hb_q, hb_set;
    logic [HB_W-1:0] hb_tmr;
    sync_2ff u_sync_hb (.clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .d(dsp_hb), .q(hb_s));
    assign hb_fail = hb_tmr == '0 && hb_s == hb_q;
    assign hb_set  = state == S_RUN && !boot_req && rs && hb_fail;
    // hb_lost survives the reboot it causes and clears on the following S_POR entry.
    always_ff @(posedge clk_sys or negedge rst_sys_n)
        if (!rst_sys_n) begin
            hb_q    <= 1'b0;
            hb_tmr  <= HB_W'(T_HB - 1);
            hb_lost <= 1'b0;
        end else begin
            hb_q    <= hb_s;
            hb_tmr  <= (state != S_RUN || hb_s != hb_q) ? HB_W'(T_HB - 1) : (hb_tmr == '0) ? hb_tmr : hb_tmr - 1'b1;
            hb_lost <= hb_set || (hb_lost && !(state_d == S_POR && state != S_POR));
        end
`else
    assign hb_fail = 1'b0;
`endif
endmodule

// File: tb/tb_dsp_boot_seq.sv
// tb_dsp_boot_seq: directed and random boot sequences checked against a phase/duration model.
module tb_dsp_boot_seq;
    localparam int T_POR = 8, T_SETUP = 4, T_HOLD = 4, T_STAT_TO = 20, MAX_RETRY = 2;
    localparam int P_POR = 0, P_SETUP = 1, P_HOLD = 2, P_WAIT = 3, P_RUN = 4, P_FAULT = 5;
    logic clk_sys = 1'b0, rst_sys_n = 1'b0, boot_req = 1'b0, dsp_rstn_state = 1'b0;
    logic dsp_porn, dsp_resetfulln, strap_oe, endian_val, boot_done, boot_fault;
    logic [12:0] strap_val;
    logic [1:0] retry_cnt;
    int total = 0, bad = 0, cyc = 0;
    int m_ph, m_left, m_retry;
    logic h1, h2;
    dsp_boot_seq #(.T_POR(T_POR), .T_SETUP(T_SETUP), .T_HOLD(T_HOLD), .T_STAT_TO(T_STAT_TO),
                   .MAX_RETRY(MAX_RETRY), .CNT_W(20)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .boot_req(boot_req), .dsp_rstn_state(dsp_rstn_state),
        .dsp_porn(dsp_porn), .dsp_resetfulln(dsp_resetfulln), .strap_oe(strap_oe), .strap_val(strap_val),
        .endian_val(endian_val), .boot_done(boot_done), .boot_fault(boot_fault), .retry_cnt(retry_cnt));
    always #5 clk_sys = ~clk_sys;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_ph = P_POR; m_left = T_POR; m_retry = 0; h1 = 1'b0; h2 = 1'b0;
    endtask
    task automatic model_fail();
        if (m_retry < MAX_RETRY) begin m_retry++; m_ph = P_POR; m_left = T_POR; end
        else m_ph = P_FAULT;
    endtask
    // Status seen by the sequencer is the input as it stood two clock edges earlier.
    task automatic model_edge(input logic req, input logic stat);
        logic rs;
        rs = h2; h2 = h1; h1 = stat;
        case (m_ph)
            P_POR:   if (--m_left == 0) begin m_ph = P_SETUP; m_left = T_SETUP; end
            P_SETUP: if (--m_left == 0) begin m_ph = P_HOLD; m_left = T_HOLD; end
            P_HOLD:  if (--m_left == 0) begin m_ph = P_WAIT; m_left = T_STAT_TO; end
            P_WAIT:  if (rs) m_ph = P_RUN; else if (--m_left == 0) model_fail();
            P_RUN:   if (req) begin m_ph = P_POR; m_left = T_POR; m_retry = 0; end
                     else if (!rs) model_fail();
            default: if (req) begin m_ph = P_POR; m_left = T_POR; m_retry = 0; end
        endcase
    endtask
    task automatic check_all();
        chk("porn", dsp_porn, m_ph != P_POR && m_ph != P_FAULT);
        chk("fulln", dsp_resetfulln, m_ph == P_HOLD || m_ph == P_WAIT || m_ph == P_RUN);
        chk("oe", strap_oe, m_ph <= P_HOLD);
        chk("done", boot_done, m_ph == P_RUN);
        chk("fault", boot_fault, m_ph == P_FAULT);
        chk("retry", retry_cnt, 16'(m_retry));
        chk("strap", strap_val, 16'h1706);
        chk("endian", endian_val, 1'b1);
    endtask
    task automatic tick();
        @(posedge clk_sys);
        model_edge(boot_req, dsp_rstn_state);
        #1;
        cyc++;
        check_all();
    endtask
    task automatic do_reset();
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        cyc = 0;
    endtask
    initial begin
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 7) chk("porn_pre", dsp_porn, 1'b0);
            if (i == 8) chk("porn_rise", dsp_porn, 1'b1);
            if (i == 11) chk("fulln_pre", dsp_resetfulln, 1'b0);
            if (i == 12) chk("fulln_rise", dsp_resetfulln, 1'b1);
            if (i == 15) chk("oe_pre", strap_oe, 1'b1);
            if (i == 16) chk("oe_fall", strap_oe, 1'b0);
            if (i == 20) dsp_rstn_state = 1'b1;
            if (i == 22) chk("done_pre", boot_done, 1'b0);
            if (i == 23) chk("done_rise", boot_done, 1'b1);
        end
        dsp_rstn_state = 1'b0;
        tick();
        dsp_rstn_state = 1'b1;
        repeat (3) tick();
        chk("run_drop_done", boot_done, 1'b0);
        chk("run_drop_retry", retry_cnt, 2'd1);
        repeat (40) tick();
        chk("reboot_done", boot_done, 1'b1);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        chk("req_clear_retry", retry_cnt, 2'd0);
        chk("req_porn", dsp_porn, 1'b0);
        do_reset();
        dsp_rstn_state = 1'b0;
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (i == 36) chk("retry1", retry_cnt, 2'd1);
            if (i == 72) chk("retry2", retry_cnt, 2'd2);
            if (i == 107) chk("fault_pre", boot_fault, 1'b0);
            if (i == 108) chk("fault_set", boot_fault, 1'b1);
        end
        chk("fault_porn", dsp_porn, 1'b0);
        chk("fault_oe", strap_oe, 1'b0);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        chk("fault_clear", boot_fault, 1'b0);
        chk("fault_retry_clear", retry_cnt, 2'd0);
        for (int i = 1; i <= 12; i++) begin
            boot_req = i == 10;
            tick();
            if (i == 7) chk("por2_pre", dsp_porn, 1'b0);
            if (i == 8) chk("por2_rise", dsp_porn, 1'b1);
            if (i == 11) chk("setup_req_ign", dsp_resetfulln, 1'b0);
            if (i == 12) chk("setup_req_hold", dsp_resetfulln, 1'b1);
        end
        boot_req = 1'b0;
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            if (i == 34) dsp_rstn_state = 1'b1;
            tick();
        end
        chk("tie_done", boot_done, 1'b1);
        chk("tie_retry", retry_cnt, 2'd0);
        dsp_rstn_state = 1'b0;
        do_reset();
        repeat (14) tick();
        chk("hold_state", dsp_resetfulln, 1'b1);
        do_reset();
        chk("rst_porn", dsp_porn, 1'b0);
        chk("rst_oe", strap_oe, 1'b1);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) dsp_rstn_state = ~dsp_rstn_state;
            boot_req = $urandom_range(0, 59) == 0;
            tick();
        end
        boot_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
